// File: rtl/commit_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : commit_checker_pkg
// Brief    : Shared enums and default parameters for the commit skew checker.
// Revision : 1.0
// ============================================================================
package commit_checker_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam int c_DEF_NCH     = 2;
    localparam int c_DEF_W       = 64;
    localparam int c_DEF_DEPTH   = 4;
    localparam int c_DEF_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/skew_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skew_fifo
// Brief    : Synchronous FIFO with full/empty/count and a synchronous flush.
// Revision : 1.0
// ============================================================================
module skew_fifo
    import commit_checker_pkg::*;
#(
    parameter int W     = c_DEF_W,
    parameter int DEPTH = c_DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          w_wr;
    logic          w_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_rd = pop_i && !empty_o;
    assign w_wr = push_i && (!full_o || w_rd);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/commit_skew_checker.sv
`default_nettype none
// ============================================================================
// Module   : commit_skew_checker
// Brief    : Per-lane DUT vs reference commit comparator with skew FIFOs.
//            Define CHECKER_CAPTURE_EN to capture the first mismatching pair.
// Revision : 1.0
// ============================================================================
module commit_skew_checker
    import commit_checker_pkg::*;
#(
    parameter int NCH     = c_DEF_NCH,
    parameter int W       = c_DEF_W,
    parameter int DEPTH   = c_DEF_DEPTH,
    parameter int TIMEOUT = c_DEF_TIMEOUT,
    localparam int LW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [NCH-1:0]   dut_valid_i,
    input  logic [NCH*W-1:0] dut_data_i,
    input  logic [NCH-1:0]   ref_valid_i,
    input  logic [NCH*W-1:0] ref_data_i,
    input  logic [W-1:0]     cmp_mask_i,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [LW-1:0]    err_lane_o,
    output logic [31:0]      match_count_o,
    output logic [W-1:0]     cap_dut_o,
    output logic [W-1:0]     cap_ref_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic                   w_run;
    logic                   w_flush;
    logic [NCH-1:0][W-1:0]  w_dut_head;
    logic [NCH-1:0][W-1:0]  w_ref_head;
    logic [NCH-1:0]         w_match;
    err_code_e              w_lane_code [NCH];
    logic                   w_any_err;
    logic [LW-1:0]          w_sel_lane;
    err_code_e              w_sel_code;
    logic                   err_q;
    err_code_e              err_code_q;
    logic [LW-1:0]          err_lane_q;
    logic [31:0]            match_count_q, match_count_d;
    logic [32:0]            w_match_sum;

    // Strobes seen while enable is low are dropped and the lanes are flushed.
    assign w_run   = (state_q == ST_RUN) && enable_i;
    assign w_flush = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !enable_i);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_lane
            logic          w_dut_empty, w_ref_empty;
            logic          w_dut_full, w_ref_full;
            logic [AW:0]   w_dut_count, w_ref_count;
            logic          w_push_dut, w_push_ref, w_pop;
            logic          w_one_sided, w_mismatch, w_overflow, w_timeout;
            logic [TW-1:0] tmo_q, tmo_d;

            assign w_push_dut  = w_run && dut_valid_i[i];
            assign w_push_ref  = w_run && ref_valid_i[i];
            assign w_pop       = w_run && !w_dut_empty && !w_ref_empty;
            assign w_one_sided = (w_dut_count != '0) ^ (w_ref_count != '0);

            skew_fifo #(.W(W), .DEPTH(DEPTH)) u_dut_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (w_flush),
                .push_i  (w_push_dut),
                .data_i  (dut_data_i[i*W +: W]),
                .pop_i   (w_pop),
                .data_o  (w_dut_head[i]),
                .full_o  (w_dut_full),
                .empty_o (w_dut_empty),
                .count_o (w_dut_count)
            );

            skew_fifo #(.W(W), .DEPTH(DEPTH)) u_ref_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (w_flush),
                .push_i  (w_push_ref),
                .data_i  (ref_data_i[i*W +: W]),
                .pop_i   (w_pop),
                .data_o  (w_ref_head[i]),
                .full_o  (w_ref_full),
                .empty_o (w_ref_empty),
                .count_o (w_ref_count)
            );

            assign w_mismatch = w_pop && (|((w_dut_head[i] ^ w_ref_head[i]) & cmp_mask_i));
            assign w_match[i] = w_pop && !w_mismatch;
            assign w_overflow = (w_push_dut && w_dut_full && !w_pop)
                             || (w_push_ref && w_ref_full && !w_pop);
            assign w_timeout  = w_run && w_one_sided && (tmo_q == TW'(TIMEOUT - 1));

            assign w_lane_code[i] = w_mismatch ? ERR_MISMATCH :
                                    w_overflow ? ERR_OVERFLOW :
                                    w_timeout  ? ERR_TIMEOUT  : ERR_NONE;

            always_comb begin
                tmo_d = tmo_q;
                if (w_flush) begin
                    tmo_d = '0;
                end else if (w_run) begin
                    if (w_pop || !w_one_sided) tmo_d = '0;
                    else if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + TW'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) tmo_q <= '0;
                else         tmo_q <= tmo_d;
            end
        end
    endgenerate

`ifdef CHECKER_CAPTURE_EN
    logic [W-1:0] w_sel_dut, w_sel_ref;
    logic [W-1:0] cap_dut_q, cap_ref_q;
`endif

    // Descending scan so the lowest-numbered erroring lane is selected last.
    always_comb begin
        w_any_err  = 1'b0;
        w_sel_lane = '0;
        w_sel_code = ERR_NONE;
`ifdef CHECKER_CAPTURE_EN
        w_sel_dut  = '0;
        w_sel_ref  = '0;
`endif
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_lane_code[i] != ERR_NONE) begin
                w_any_err  = 1'b1;
                w_sel_lane = LW'(i);
                w_sel_code = w_lane_code[i];
`ifdef CHECKER_CAPTURE_EN
                w_sel_dut  = w_dut_head[i];
                w_sel_ref  = w_ref_head[i];
`endif
            end
        end
    end

    always_comb begin
        w_match_sum = {1'b0, match_count_q};
        for (int i = 0; i < NCH; i++) begin
            w_match_sum = w_match_sum + 33'(w_match[i]);
        end
        match_count_d = match_count_q;
        if (w_run) match_count_d = w_match_sum[32] ? '1 : w_match_sum[31:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_RUN;
            ST_RUN: begin
                if (w_any_err)      state_d = ST_FAIL;
                else if (!enable_i) state_d = ST_IDLE;
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_lane_q    <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            match_count_q <= match_count_d;
            if ((state_q == ST_RUN) && w_any_err && !err_q) begin
                err_q      <= 1'b1;
                err_code_q <= w_sel_code;
                err_lane_q <= w_sel_lane;
            end
        end
    end

`ifdef CHECKER_CAPTURE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_dut_q <= '0;
            cap_ref_q <= '0;
        end else if ((state_q == ST_RUN) && w_any_err && !err_q
                     && (w_sel_code == ERR_MISMATCH)) begin
            cap_dut_q <= w_sel_dut;
            cap_ref_q <= w_sel_ref;
        end
    end
    assign cap_dut_o = cap_dut_q;
    assign cap_ref_o = cap_ref_q;
`else
    assign cap_dut_o = '0;
    assign cap_ref_o = '0;
`endif

    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign err_lane_o    = err_lane_q;
    assign match_count_o = match_count_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_skew_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_skew_checker
// Brief    : Directed self-checking bench for commit_skew_checker (defaults).
// Revision : 1.0
// ============================================================================
module tb_commit_skew_checker;

    localparam int NCH = 2;
    localparam int W   = 64;
    localparam int LW  = 1;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             enable_i = 1'b0;
    logic [NCH-1:0]   dut_valid_i = '0;
    logic [NCH*W-1:0] dut_data_i = '0;
    logic [NCH-1:0]   ref_valid_i = '0;
    logic [NCH*W-1:0] ref_data_i = '0;
    logic [W-1:0]     cmp_mask_i = '1;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [LW-1:0]    err_lane_o;
    logic [31:0]      match_count_o;
    logic [W-1:0]     cap_dut_o;
    logic [W-1:0]     cap_ref_o;

    int tests_run = 0;
    int fails = 0;
    logic [W-1:0] exp_cd, exp_cr;

    commit_skew_checker #(.NCH(NCH), .W(W), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .dut_valid_i   (dut_valid_i),
        .dut_data_i    (dut_data_i),
        .ref_valid_i   (ref_valid_i),
        .ref_data_i    (ref_data_i),
        .cmp_mask_i    (cmp_mask_i),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .err_lane_o    (err_lane_o),
        .match_count_o (match_count_o),
        .cap_dut_o     (cap_dut_o),
        .cap_ref_o     (cap_ref_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dut_valid_i = '0;
        ref_valid_i = '0;
    endtask

    task automatic push(input int lane, input logic dv, input logic [W-1:0] dd,
                        input logic rv, input logic [W-1:0] rd);
        dut_valid_i[lane]          = dv;
        dut_data_i[lane*W +: W]    = dd;
        ref_valid_i[lane]          = rv;
        ref_data_i[lane*W +: W]    = rd;
    endtask

    task automatic do_reset();
        idle();
        enable_i   = 1'b0;
        cmp_mask_i = '1;
        rst_ni     = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %0h exp 0", err_o); end
        tests_run++; if (err_code_o !== 2'd0) begin fails++; $display("FAIL reset_code: got %0h exp 0", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b0) begin fails++; $display("FAIL reset_lane: got %0h exp 0", err_lane_o); end
        tests_run++; if (match_count_o !== 32'd0) begin fails++; $display("FAIL reset_mc: got %0h exp 0", match_count_o); end
        tests_run++; if (cap_dut_o !== '0) begin fails++; $display("FAIL reset_capdut: got %0h exp 0", cap_dut_o); end
        tests_run++; if (cap_ref_o !== '0) begin fails++; $display("FAIL reset_capref: got %0h exp 0", cap_ref_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
    endtask

    task automatic test_delayed_match();
        push(0, 1'b1, 64'h10, 1'b0, 64'h0);
        tick();
        idle();
        tick();
        tick();
        push(0, 1'b0, 64'h0, 1'b1, 64'h10);
        tick();
        idle();
        tests_run++; if (match_count_o !== 32'd0) begin fails++; $display("FAIL skew_mc_early: got %0d exp 0", match_count_o); end
        tick();
        tests_run++; if (match_count_o !== 32'd1) begin fails++; $display("FAIL skew_mc: got %0d exp 1", match_count_o); end
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL skew_err: got %0h exp 0", err_o); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            push(0, 1'b1, 64'hDEAD_0000_0000_0000 | 64'(k), 1'b1, 64'hDEAD_0000_0000_0000 | 64'(k));
            push(1, 1'b1, 64'(k + 100), 1'b1, 64'(k + 100));
            tick();
        end
        idle();
        tick();
        tests_run++; if (match_count_o !== 32'd13) begin fails++; $display("FAIL b2b_mc: got %0d exp 13", match_count_o); end
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL b2b_err: got %0h exp 0", err_o); end
    endtask

    task automatic test_flush();
        push(0, 1'b1, 64'h77, 1'b0, 64'h0);
        tick();
        enable_i = 1'b0;
        push(0, 1'b1, 64'h99, 1'b1, 64'h98);
        tick();
        idle();
        enable_i = 1'b1;
        push(1, 1'b1, 64'h66, 1'b0, 64'h0);
        tick();
        idle();
        push(0, 1'b1, 64'h55, 1'b1, 64'h55);
        tick();
        idle();
        tick();
        tests_run++; if (match_count_o !== 32'd14) begin fails++; $display("FAIL flush_mc: got %0d exp 14", match_count_o); end
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL flush_err: got %0h exp 0", err_o); end
        repeat (18) tick();
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL idle_ignored: got err %0h code %0h exp 0", err_o, err_code_o); end
    endtask

    task automatic test_mask();
        cmp_mask_i = ~64'h1;
        push(1, 1'b1, 64'hA5, 1'b1, 64'hA4);
        tick();
        idle();
        tick();
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL mask_err: got %0h exp 0", err_o); end
        tests_run++; if (match_count_o !== 32'd15) begin fails++; $display("FAIL mask_mc: got %0d exp 15", match_count_o); end
    endtask

    task automatic test_mismatch();
        cmp_mask_i = '1;
`ifdef CHECKER_CAPTURE_EN
        exp_cd = 64'hA5; exp_cr = 64'hA4;
`else
        exp_cd = '0; exp_cr = '0;
`endif
        push(1, 1'b1, 64'hA5, 1'b1, 64'hA4);
        tick();
        idle();
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL mm_early: got %0h exp 0", err_o); end
        tick();
        tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL mm_err: got %0h exp 1", err_o); end
        tests_run++; if (err_code_o !== 2'd1) begin fails++; $display("FAIL mm_code: got %0h exp 1", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b1) begin fails++; $display("FAIL mm_lane: got %0h exp 1", err_lane_o); end
        tests_run++; if (cap_dut_o !== exp_cd) begin fails++; $display("FAIL mm_capdut: got %0h exp %0h", cap_dut_o, exp_cd); end
        tests_run++; if (cap_ref_o !== exp_cr) begin fails++; $display("FAIL mm_capref: got %0h exp %0h", cap_ref_o, exp_cr); end
        push(0, 1'b1, 64'h5, 1'b1, 64'h5);
        push(1, 1'b1, 64'h1, 1'b1, 64'h2);
        tick();
        idle();
        tick();
        tests_run++; if (match_count_o !== 32'd15) begin fails++; $display("FAIL fail_frozen_mc: got %0d exp 15", match_count_o); end
        tests_run++; if (err_code_o !== 2'd1 || err_lane_o !== 1'b1) begin fails++; $display("FAIL fail_sticky: got code %0h lane %0h exp 1/1", err_code_o, err_lane_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            push(0, 1'b1, 64'(k), 1'b0, 64'h0);
            tick();
            if (k == 4) begin
                tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL ovf_early: got %0h exp 0", err_o); end
            end
        end
        idle();
        tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_err: got %0h exp 1", err_o); end
        tests_run++; if (err_code_o !== 2'd2) begin fails++; $display("FAIL ovf_code: got %0h exp 2", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b0) begin fails++; $display("FAIL ovf_lane: got %0h exp 0", err_lane_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        push(0, 1'b1, 64'h42, 1'b0, 64'h0);
        tick();
        idle();
        repeat (15) tick();
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL tmo_early: got %0h exp 0", err_o); end
        tick();
        tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL tmo_err: got %0h exp 1", err_o); end
        tests_run++; if (err_code_o !== 2'd3) begin fails++; $display("FAIL tmo_code: got %0h exp 3", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b0) begin fails++; $display("FAIL tmo_lane: got %0h exp 0", err_lane_o); end
    endtask

    task automatic test_priority();
        do_reset();
`ifdef CHECKER_CAPTURE_EN
        exp_cd = 64'h1; exp_cr = 64'h2;
`else
        exp_cd = '0; exp_cr = '0;
`endif
        push(1, 1'b1, 64'h1, 1'b0, 64'h0);
        tick();
        idle();
        repeat (14) tick();
        push(0, 1'b1, 64'h1, 1'b1, 64'h2);
        tick();
        idle();
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL prio_early: got %0h exp 0", err_o); end
        tick();
        tests_run++; if (err_code_o !== 2'd1) begin fails++; $display("FAIL prio_code: got %0h exp 1", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b0) begin fails++; $display("FAIL prio_lane: got %0h exp 0", err_lane_o); end
        tests_run++; if (cap_dut_o !== exp_cd) begin fails++; $display("FAIL prio_capdut: got %0h exp %0h", cap_dut_o, exp_cd); end
        tests_run++; if (cap_ref_o !== exp_cr) begin fails++; $display("FAIL prio_capref: got %0h exp %0h", cap_ref_o, exp_cr); end
    endtask

    task automatic test_reset_in_fail();
        do_reset();
        push(0, 1'b1, 64'h11, 1'b0, 64'h0);
        tick();
        push(0, 1'b1, 64'h12, 1'b0, 64'h0);
        tick();
        push(0, 1'b1, 64'h13, 1'b0, 64'h0);
        push(1, 1'b1, 64'hA5, 1'b1, 64'hA4);
        tick();
        idle();
        tick();
        tests_run++; if (err_o !== 1'b1 || err_lane_o !== 1'b1) begin fails++; $display("FAIL rif_fail: got err %0h lane %0h exp 1/1", err_o, err_lane_o); end
        #2 rst_ni = 1'b0;
        #1;
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL rif_err: got %0h exp 0", err_o); end
        tests_run++; if (err_code_o !== 2'd0) begin fails++; $display("FAIL rif_code: got %0h exp 0", err_code_o); end
        tests_run++; if (err_lane_o !== 1'b0) begin fails++; $display("FAIL rif_lane: got %0h exp 0", err_lane_o); end
        tests_run++; if (cap_dut_o !== '0 || cap_ref_o !== '0) begin fails++; $display("FAIL rif_cap: got %0h/%0h exp 0/0", cap_dut_o, cap_ref_o); end
        enable_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
        push(0, 1'b1, 64'h33, 1'b1, 64'h33);
        tick();
        idle();
        tick();
        tests_run++; if (match_count_o !== 32'd1) begin fails++; $display("FAIL rif_mc: got %0d exp 1", match_count_o); end
        tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL rif_after_err: got %0h exp 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_delayed_match();
        test_back_to_back();
        test_flush();
        test_mask();
        test_mismatch();
        test_overflow();
        test_timeout();
        test_priority();
        test_reset_in_fail();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
